// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU control unit and
// the debug/loader port, with latched requests and a transfer watchdog.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            cpu_op,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_done,
  input  logic [1:0]            dbg_op,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_done,
  output logic [1:0]            mem_op,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_done,
  output logic                  grant,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  err_clear
);

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_ctrl_op_e;

  typedef enum logic {IDLE, XFER} state_e;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_e          state, state_nxt;
  logic            grant_nxt;
  logic            cpu_req, dbg_req;
  logic            take, xfer_end, to_hit;
  logic [CNT_W-1:0] cnt;
  logic [DATA_WIDTH-1:0] done_rdata;

  assign cpu_req = (cpu_op == MEM_READ) || (cpu_op == MEM_WRITE);
  assign dbg_req = (dbg_op == MEM_READ) || (dbg_op == MEM_WRITE);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    take      = 1'b0;
    xfer_end  = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          take      = 1'b1;
          // Under contention the previous owner yields.
          grant_nxt = (cpu_req && dbg_req) ? ~grant : dbg_req;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (mem_done) begin
          xfer_end  = 1'b1;
          state_nxt = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == TO_LAST)) begin
          xfer_end  = 1'b1;
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Completion is steered to the owner in the same cycle; an abort returns zero data.
  assign done_rdata = mem_done ? mem_rdata : '0;
  assign cpu_done   = xfer_end & ~grant;
  assign dbg_done   = xfer_end & grant;
  assign cpu_rdata  = cpu_done ? done_rdata : '0;
  assign dbg_rdata  = dbg_done ? done_rdata : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 1'b1;
      busy        <= 1'b0;
      mem_op      <= MEM_NOP;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (take) begin
        mem_op    <= grant_nxt ? dbg_op    : cpu_op;
        mem_addr  <= grant_nxt ? dbg_addr  : cpu_addr;
        mem_wdata <= grant_nxt ? dbg_wdata : cpu_wdata;
        busy      <= 1'b1;
        cnt       <= '0;
      end else if (xfer_end) begin
        mem_op <= MEM_NOP;
        busy   <= 1'b0;
      end else if (state == XFER) begin
        cnt <= sat_inc(cnt);
      end
      if (to_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clear) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory issues and done pulses are
// queued as stimulus is driven and compared by a negedge monitor.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;
  localparam logic [1:0] NOP = 2'd0;
  localparam logic [1:0] RD  = 2'd1;
  localparam logic [1:0] WR  = 2'd2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    cpu_op = NOP, dbg_op = NOP;
  logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dbg_wdata = '0;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          cpu_done, dbg_done;
  logic [1:0]    mem_op;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_done = 1'b0;
  logic          grant, busy, timeout_err;
  logic          err_clear = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          g;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } issue_t;

  typedef struct {
    logic          owner;
    logic [DW-1:0] rdata;
  } done_t;

  issue_t iq[$];
  done_t  dq[$];
  logic [1:0] prev_op = NOP;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dbg_op(dbg_op), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .grant(grant), .busy(busy), .timeout_err(timeout_err), .err_clear(err_clear)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Monitor: each fresh memory operation and each done pulse consumes one expectation.
  always @(negedge clock) begin
    issue_t ei;
    done_t  ed;
    logic   own;
    logic [DW-1:0] rd;
    if (mem_op != NOP && prev_op == NOP) begin
      checks++;
      if (iq.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected got g=%0d op=%0d addr=%h wdata=%h", grant, mem_op, mem_addr, mem_wdata);
      end else begin
        ei = iq.pop_front();
        if (grant !== ei.g || mem_op !== ei.op || mem_addr !== ei.addr || mem_wdata !== ei.wdata) begin
          errors++;
          $display("FAIL issue got g=%0d op=%0d addr=%h wdata=%h want g=%0d op=%0d addr=%h wdata=%h",
                   grant, mem_op, mem_addr, mem_wdata, ei.g, ei.op, ei.addr, ei.wdata);
        end
      end
    end
    prev_op <= mem_op;
    if (cpu_done || dbg_done) begin
      checks++;
      own = dbg_done;
      rd  = dbg_done ? dbg_rdata : cpu_rdata;
      if (cpu_done && dbg_done) begin
        errors++;
        $display("FAIL done_both got cpu_done=1 dbg_done=1 want one");
      end else if (dq.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected got owner=%0d rdata=%h want none", own, rd);
      end else begin
        ed = dq.pop_front();
        if (own !== ed.owner || rd !== ed.rdata) begin
          errors++;
          $display("FAIL done got owner=%0d rdata=%h want owner=%0d rdata=%h", own, rd, ed.owner, ed.rdata);
        end
      end
    end
    if ((!cpu_done && cpu_rdata !== '0) || (!dbg_done && dbg_rdata !== '0)) begin
      checks++;
      errors++;
      $display("FAIL rdata_idle got cpu=%h dbg=%h want 0 without done", cpu_rdata, dbg_rdata);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_op !== NOP || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mem got op=%0d addr=%h wdata=%h want 0/0/0", mem_op, mem_addr, mem_wdata);
    end
    checks++;
    if (grant !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got grant=%0d busy=%0d terr=%0d want 1/0/0", grant, busy, timeout_err);
    end
    checks++;
    if (cpu_done !== 1'b0 || dbg_done !== 1'b0 || cpu_rdata !== '0 || dbg_rdata !== '0) begin
      errors++;
      $display("FAIL reset_done got cd=%0d dd=%0d cr=%h dr=%h want zeros", cpu_done, dbg_done, cpu_rdata, dbg_rdata);
    end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_cpu_read();
    cpu_op = RD; cpu_addr = 8'h10; cpu_wdata = 8'h00;
    iq.push_back('{1'b0, RD, 8'h10, 8'h00});
    tick();
    checks++;
    if (mem_op !== RD || mem_addr !== 8'h10 || busy !== 1'b1 || grant !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_grant got op=%0d addr=%h busy=%0d grant=%0d want 1/10/1/0", mem_op, mem_addr, busy, grant);
    end
    cpu_op = NOP;
    tick();
    tick();
    mem_rdata = 8'hA5; mem_done = 1'b1;
    dq.push_back('{1'b0, 8'hA5});
    #1;
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 8'hA5 || dbg_done !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_done got cd=%0d cr=%h dd=%0d want 1/a5/0", cpu_done, cpu_rdata, dbg_done);
    end
    tick();
    mem_done = 1'b0; mem_rdata = '0;
    checks++;
    if (busy !== 1'b0 || mem_op !== NOP || cpu_done !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_end got busy=%0d op=%0d cd=%0d want 0/0/0", busy, mem_op, cpu_done);
    end
  endtask

  task automatic test_contention();
    logic own;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_op = RD; cpu_addr = 8'h11; cpu_wdata = 8'h00;
    dbg_op = WR; dbg_addr = 8'h20; dbg_wdata = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) iq.push_back('{1'b0, RD, 8'h11, 8'h00});
      else            iq.push_back('{1'b1, WR, 8'h20, 8'h3C});
    end
    for (int k = 0; k < 4; k++) begin
      own = (k % 2 == 1);
      tick();
      checks++;
      if (grant !== own || busy !== 1'b1) begin
        errors++;
        $display("FAIL contention_grant%0d got grant=%0d busy=%0d want %0d/1", k, grant, busy, own);
      end
      tick();
      mem_done = 1'b1; mem_rdata = 8'h40 + 8'(k);
      dq.push_back('{own, 8'h40 + 8'(k)});
      tick();
      mem_done = 1'b0; mem_rdata = '0;
      if (k == 3) begin
        cpu_op = NOP; dbg_op = NOP;
      end
      checks++;
      if (mem_op !== NOP || busy !== 1'b0) begin
        errors++;
        $display("FAIL contention_gap%0d got op=%0d busy=%0d want 0/0", k, mem_op, busy);
      end
    end
    tick();
  endtask

  task automatic test_input_hold();
    dbg_op = WR; dbg_addr = 8'h20; dbg_wdata = 8'h3C;
    iq.push_back('{1'b1, WR, 8'h20, 8'h3C});
    tick();
    dbg_op = NOP; dbg_addr = 8'hFF; dbg_wdata = 8'h00;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (mem_addr !== 8'h20 || mem_op !== WR || mem_wdata !== 8'h3C) begin
        errors++;
        $display("FAIL input_hold%0d got op=%0d addr=%h wdata=%h want 2/20/3c", k, mem_op, mem_addr, mem_wdata);
      end
    end
    mem_done = 1'b1; mem_rdata = 8'h77;
    dq.push_back('{1'b1, 8'h77});
    tick();
    mem_done = 1'b0; mem_rdata = '0;
    tick();
  endtask

  task automatic test_watchdog();
    cpu_op = RD; cpu_addr = 8'h30;
    iq.push_back('{1'b0, RD, 8'h30, 8'h00});
    tick();
    cpu_op = NOP;
    mem_rdata = 8'hEE;
    tick();
    tick();
    checks++;
    if (cpu_done !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_early got cpu_done=%0d want 0", cpu_done);
    end
    tick();
    dq.push_back('{1'b0, 8'h00});
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== '0) begin
      errors++;
      $display("FAIL watchdog_pulse got cd=%0d cr=%h want 1/00", cpu_done, cpu_rdata);
    end
    tick();
    mem_rdata = '0;
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || mem_op !== NOP || cpu_done !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_abort got terr=%0d busy=%0d op=%0d cd=%0d want 1/0/0/0", timeout_err, busy, mem_op, cpu_done);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL watchdog_sticky got terr=%0d want 1", timeout_err);
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_clear got terr=%0d want 0", timeout_err);
    end
  endtask

  task automatic test_timeout_tie();
    cpu_op = RD; cpu_addr = 8'h31;
    iq.push_back('{1'b0, RD, 8'h31, 8'h00});
    tick();
    cpu_op = NOP;
    tick();
    tick();
    tick();
    mem_done = 1'b1; mem_rdata = 8'h5A;
    dq.push_back('{1'b0, 8'h5A});
    #1;
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL tie_done got cd=%0d cr=%h want 1/5a", cpu_done, cpu_rdata);
    end
    tick();
    mem_done = 1'b0; mem_rdata = '0;
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tie_err got terr=%0d busy=%0d want 0/0", timeout_err, busy);
    end
  endtask

  task automatic test_reset_mid();
    cpu_op = RD; cpu_addr = 8'h40;
    iq.push_back('{1'b0, RD, 8'h40, 8'h00});
    tick();
    tick();
    dbg_op = RD; dbg_addr = 8'h50;
    mem_done = 1'b1; mem_rdata = 8'h99;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_op !== NOP || busy !== 1'b0 || cpu_done !== 1'b0 || dbg_done !== 1'b0 || grant !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got op=%0d busy=%0d cd=%0d dd=%0d grant=%0d want 0/0/0/0/1",
               mem_op, busy, cpu_done, dbg_done, grant);
    end
    tick();
    mem_done = 1'b0; mem_rdata = '0;
    reset = 1'b0;
    iq.push_back('{1'b0, RD, 8'h40, 8'h00});
    tick();
    cpu_op = NOP; dbg_op = NOP;
    checks++;
    if (grant !== 1'b0 || mem_op !== RD || mem_addr !== 8'h40) begin
      errors++;
      $display("FAIL reset_regrant got grant=%0d op=%0d addr=%h want 0/1/40", grant, mem_op, mem_addr);
    end
    mem_done = 1'b1; mem_rdata = 8'h12;
    dq.push_back('{1'b0, 8'h12});
    tick();
    mem_done = 1'b0; mem_rdata = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_contention();
    test_input_hold();
    test_watchdog();
    test_timeout_tie();
    test_reset_mid();
    tick();
    checks++;
    if (iq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got issues=%0d dones=%0d want 0/0", iq.size(), dq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
